stage_pipe_reg: RTL and testbench

STAGE_PIPE_REG -- requirements
Module: stage_pipe_reg

---
 rtl/stage_pipe_reg_pkg.sv | 55 +++++
 rtl/sat_counter.sv | 38 +++
 rtl/stage_pipe_reg.sv | 134 +++++++++++++
 tb/tb_stage_pipe_reg.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_pipe_reg_pkg.sv
// Shared definitions for the pipeline stage register: stall encodings, reset
// level, stall-vector width, default field widths and the per-cycle action decode.
package stage_pipe_reg_pkg;

    // Stall vector: one bit per pipeline stage, 1 = stop that stage.
    localparam int unsigned STALL_W = 6;
    localparam logic        STOP    = 1'b1;
    localparam logic        NOSTOP  = 1'b0;

    // Level of Rst_n that resets the block (synchronous, active-high).
    localparam logic RstEnable = 1'b1;

    // Default payload field widths. The block itself treats the payload as opaque.
    localparam int unsigned ALUOP_W    = 8;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned SPARE_W    = 6;

    // Default parameter values for stage_pipe_reg.
    localparam int unsigned DEF_PAYLOAD_W = 137;
    localparam int unsigned DEF_WE_W      = 2;
    localparam int unsigned DEF_SCR_W     = 64;
    localparam int unsigned DEF_CNT_W     = 2;
    localparam int unsigned DEF_STAGE_IDX = 3;
    localparam int unsigned DEF_PERF_W    = 16;

    // Highest legal stage index; stall[idx + 1] must still exist.
    localparam int unsigned MAX_STAGE_IDX = STALL_W - 2;

    // The non-reset action a stage performs in a given cycle.
    typedef enum logic [1:0] {
        ActFlush,
        ActBubble,
        ActAdvance,
        ActHold
    } stage_act_e;

    // Priority decode: flush > bubble > advance > hold (reset is handled by the flops).
    function automatic stage_act_e stage_act(input logic flush,
                                             input logic stall_this,
                                             input logic stall_down);
        stage_act_e act;
        if (flush) begin
            act = ActFlush;
        end else if (stall_this == STOP && stall_down == NOSTOP) begin
            act = ActBubble;
        end else if (stall_this == NOSTOP) begin
            act = ActAdvance;
        end else begin
            act = ActHold;
        end
        return act;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and a clear that wins over increment.
module sat_counter
    import stage_pipe_reg_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         Rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Next count: clear has priority, increment stops at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (Rst_n == RstEnable) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/stage_pipe_reg.sv
// Pipeline stage register with flush / bubble / advance / hold control, a
// scratch path that keeps multi-cycle execute state alive while the stage is
// stalled, and a saturating stall-cycle counter.
module stage_pipe_reg
    import stage_pipe_reg_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = DEF_PAYLOAD_W,
    parameter int unsigned WE_W      = DEF_WE_W,
    parameter int unsigned SCR_W     = DEF_SCR_W,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned STAGE_IDX = DEF_STAGE_IDX,
    parameter int unsigned PERF_W    = DEF_PERF_W
) (
    input  logic                 clk,
    input  logic                 Rst_n,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic                 perf_clr,
    input  logic                 in_valid,
    input  logic [WE_W-1:0]      in_we,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [SCR_W-1:0]     scr_i,
    input  logic [CNT_W-1:0]     cnt_i,
    output logic                 out_valid,
    output logic [WE_W-1:0]      out_we,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [SCR_W-1:0]     scr_o,
    output logic [CNT_W-1:0]     cnt_o,
    output logic [PERF_W-1:0]    perf_stall
);

    // Reject a stage index whose downstream stall bit would fall off the vector.
    if (STAGE_IDX > MAX_STAGE_IDX) begin : g_stage_idx_chk
        $error("stage_pipe_reg: STAGE_IDX must be in 0..4");
    end

    localparam int unsigned DOWN_IDX = STAGE_IDX + 1;

    logic stall_this;
    logic stall_down;
    assign stall_this = stall[STAGE_IDX];
    assign stall_down = stall[DOWN_IDX];

    // Only this stage's and the downstream stage's bits matter here.
    logic unused_stall;
    assign unused_stall = ^stall;

    stage_act_e act;

    logic                 valid_d,   valid_q;
    logic [WE_W-1:0]      we_d,      we_q;
    logic [PAYLOAD_W-1:0] payload_d, payload_q;
    logic [SCR_W-1:0]     scr_d,     scr_q;
    logic [CNT_W-1:0]     cnt_d,     cnt_q;

    // Next-state selection for the stage contents and the multi-cycle scratch.
    always_comb begin
        act       = stage_act(flush, stall_this, stall_down);
        valid_d   = valid_q;
        we_d      = we_q;
        payload_d = payload_q;
        scr_d     = scr_q;
        cnt_d     = cnt_q;
        unique case (act)
            ActFlush: begin
                valid_d   = 1'b0;
                we_d      = '0;
                payload_d = '0;
                scr_d     = '0;
                cnt_d     = '0;
            end
            ActBubble: begin
                // Stage stops while downstream drains: emit an empty slot but
                // keep the execute unit's partial result circulating.
                valid_d   = 1'b0;
                we_d      = '0;
                payload_d = '0;
                scr_d     = scr_i;
                cnt_d     = cnt_i;
            end
            ActAdvance: begin
                // Payload is captured even for invalid slots; only the write
                // enables are qualified so a bubble can never commit.
                valid_d   = in_valid;
                we_d      = in_we & {WE_W{in_valid}};
                payload_d = in_payload;
                scr_d     = '0;
                cnt_d     = '0;
            end
            ActHold: begin
                scr_d = scr_i;
                cnt_d = cnt_i;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Stage registers with synchronous reset that also discards any scratch.
    always_ff @(posedge clk) begin
        if (Rst_n == RstEnable) begin
            valid_q   <= 1'b0;
            we_q      <= '0;
            payload_q <= '0;
            scr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            we_q      <= we_d;
            payload_q <= payload_d;
            scr_q     <= scr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_we      = we_q;
    assign out_payload = payload_q;
    assign scr_o       = scr_q;
    assign cnt_o       = cnt_q;

    // Stall-cycle counter; flush deliberately does not touch it.
    sat_counter #(
        .W(PERF_W)
    ) u_perf_cnt (
        .clk  (clk),
        .Rst_n(Rst_n),
        .inc  (stall_this == STOP),
        .clr  (perf_clr),
        .count(perf_stall)
    );

endmodule

// File: tb/tb_stage_pipe_reg.sv
// Self-checking bench for stage_pipe_reg: a behavioural model pushes expected
// outputs into a scoreboard queue each cycle, popped and compared after the edge.
module tb_stage_pipe_reg;

    localparam int PW   = 137;
    localparam int WW   = 2;
    localparam int SW   = 64;
    localparam int CW   = 2;
    localparam int SI   = 3;
    localparam int PFW  = 16;
    localparam int PFW2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [5:0]    stall;
    logic          flush;
    logic          perf_clr;
    logic          in_valid;
    logic [WW-1:0] in_we;
    logic [PW-1:0] in_payload;
    logic [SW-1:0] scr_i;
    logic [CW-1:0] cnt_i;

    logic           out_valid,  out_valid2;
    logic [WW-1:0]  out_we,     out_we2;
    logic [PW-1:0]  out_payload, out_payload2;
    logic [SW-1:0]  scr_o,      scr_o2;
    logic [CW-1:0]  cnt_o,      cnt_o2;
    logic [PFW-1:0] perf_stall;
    logic [PFW2-1:0] perf_stall2;

    stage_pipe_reg #(
        .PAYLOAD_W(PW), .WE_W(WW), .SCR_W(SW), .CNT_W(CW), .STAGE_IDX(SI), .PERF_W(PFW)
    ) dut (
        .clk(clk), .Rst_n(rst), .stall(stall), .flush(flush), .perf_clr(perf_clr),
        .in_valid(in_valid), .in_we(in_we), .in_payload(in_payload),
        .scr_i(scr_i), .cnt_i(cnt_i),
        .out_valid(out_valid), .out_we(out_we), .out_payload(out_payload),
        .scr_o(scr_o), .cnt_o(cnt_o), .perf_stall(perf_stall)
    );

    // Narrow perf counter instance for the saturation check.
    stage_pipe_reg #(
        .PAYLOAD_W(PW), .WE_W(WW), .SCR_W(SW), .CNT_W(CW), .STAGE_IDX(SI), .PERF_W(PFW2)
    ) dut_sat (
        .clk(clk), .Rst_n(rst), .stall(stall), .flush(flush), .perf_clr(perf_clr),
        .in_valid(in_valid), .in_we(in_we), .in_payload(in_payload),
        .scr_i(scr_i), .cnt_i(cnt_i),
        .out_valid(out_valid2), .out_we(out_we2), .out_payload(out_payload2),
        .scr_o(scr_o2), .cnt_o(cnt_o2), .perf_stall(perf_stall2)
    );

    typedef struct {
        logic            v;
        logic [WW-1:0]   we;
        logic [PW-1:0]   pl;
        logic [SW-1:0]   scr;
        logic [CW-1:0]   cnt;
        logic [PFW-1:0]  perf;
        logic [PFW2-1:0] perf2;
    } exp_t;

    exp_t sb_q[$];
    exp_t m;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance the model by one cycle from the current inputs, push, clock, pop, compare.
    task automatic cycle();
        exp_t e;
        logic st_this;
        logic st_down;
        st_this = stall[SI];
        st_down = stall[SI+1];
        if (rst) begin
            m.v = 1'b0; m.we = '0; m.pl = '0; m.scr = '0; m.cnt = '0;
            m.perf = '0; m.perf2 = '0;
        end else begin
            if (flush) begin
                m.v = 1'b0; m.we = '0; m.pl = '0; m.scr = '0; m.cnt = '0;
            end else if (st_this && !st_down) begin
                m.v = 1'b0; m.we = '0; m.pl = '0; m.scr = scr_i; m.cnt = cnt_i;
            end else if (!st_this) begin
                m.v = in_valid; m.we = in_valid ? in_we : '0; m.pl = in_payload;
                m.scr = '0; m.cnt = '0;
            end else begin
                m.scr = scr_i; m.cnt = cnt_i;
            end
            if (perf_clr) begin
                m.perf = '0; m.perf2 = '0;
            end else if (st_this) begin
                if (m.perf != {PFW{1'b1}})   m.perf  = m.perf + 1'b1;
                if (m.perf2 != {PFW2{1'b1}}) m.perf2 = m.perf2 + 1'b1;
            end
        end
        sb_q.push_back(m);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            check_val("out_valid",   256'(out_valid),   256'(e.v));
            check_val("out_we",      256'(out_we),      256'(e.we));
            check_val("out_payload", 256'(out_payload), 256'(e.pl));
            check_val("scr_o",       256'(scr_o),       256'(e.scr));
            check_val("cnt_o",       256'(cnt_o),       256'(e.cnt));
            check_val("perf_stall",  256'(perf_stall),  256'(e.perf));
            check_val("perf_stall2", 256'(perf_stall2), 256'(e.perf2));
        end
    endtask

    task automatic randomize_inputs();
        in_valid   = 1'($urandom);
        in_we      = WW'($urandom);
        in_payload = PW'({$urandom, $urandom, $urandom, $urandom, $urandom});
        scr_i      = {$urandom, $urandom};
        cnt_i      = CW'($urandom);
    endtask

    logic [143:0]  a5_wide;
    logic [PW-1:0] pay_p;

    initial begin
        m = '{v: 1'b0, we: '0, pl: '0, scr: '0, cnt: '0, perf: '0, perf2: '0};
        rst = 1'b1; flush = 1'b0; perf_clr = 1'b0;
        a5_wide = {18{8'hA5}};

        // Reset with random inputs for two cycles.
        for (int i = 0; i < 2; i++) begin
            randomize_inputs();
            stall    = 6'($urandom);
            flush    = 1'($urandom);
            perf_clr = 1'($urandom);
            cycle();
        end
        check_val("reset_valid", 256'(out_valid), 256'(1'b0));
        check_val("reset_perf",  256'(perf_stall), 256'(0));
        rst = 1'b0; flush = 1'b0; perf_clr = 1'b0;

        // Advance a full-write instruction.
        stall = 6'b000000; in_valid = 1'b1; in_we = 2'b11;
        in_payload = a5_wide[PW-1:0]; scr_i = 64'hDEAD; cnt_i = 2'b10;
        cycle();
        check_val("adv_valid",   256'(out_valid),   256'(1'b1));
        check_val("adv_we",      256'(out_we),      256'(2'b11));
        check_val("adv_payload", 256'(out_payload), 256'(a5_wide[PW-1:0]));
        check_val("adv_scr",     256'(scr_o),       256'(0));

        // Bubble: this stage stalled, downstream free.
        stall = 6'b001111; scr_i = 64'h1234; cnt_i = 2'b01;
        cycle();
        check_val("bub_valid", 256'(out_valid), 256'(1'b0));
        check_val("bub_we",    256'(out_we),    256'(2'b00));
        check_val("bub_scr",   256'(scr_o),     256'(64'h1234));
        check_val("bub_cnt",   256'(cnt_o),     256'(2'b01));
        check_val("bub_perf",  256'(perf_stall), 256'(1));

        // Invalid slot: payload captured, write enables masked; clear perf too.
        stall = 6'b000000; in_valid = 1'b0; in_we = 2'b11; perf_clr = 1'b1;
        in_payload = PW'({$urandom, $urandom, $urandom, $urandom, $urandom});
        pay_p = in_payload;
        cycle();
        check_val("inv_we",      256'(out_we),      256'(2'b00));
        check_val("inv_payload", 256'(out_payload), 256'(pay_p));
        perf_clr = 1'b0;

        // Advance payload P, then hold three cycles.
        in_valid = 1'b1; in_we = 2'b01;
        in_payload = PW'({$urandom, $urandom, $urandom, $urandom, $urandom});
        pay_p = in_payload;
        cycle();
        for (int i = 0; i < 3; i++) begin
            stall = 6'b011111;
            randomize_inputs();
            cnt_i = CW'(i + 1);
            cycle();
            check_val("hold_payload", 256'(out_payload), 256'(pay_p));
            check_val("hold_cnt",     256'(cnt_o),       256'(i + 1));
        end
        check_val("hold_perf", 256'(perf_stall), 256'(3));

        // Flush during hold: data cleared, perf still counts.
        flush = 1'b1; stall = 6'b011111;
        cycle();
        check_val("flush_valid",   256'(out_valid),   256'(1'b0));
        check_val("flush_payload", 256'(out_payload), 256'(0));
        check_val("flush_scr",     256'(scr_o),       256'(0));
        check_val("flush_perf",    256'(perf_stall),  256'(4));
        flush = 1'b0;

        // Reset mid-hold with live scratch.
        stall = 6'b011111; scr_i = 64'hFFFF_0000_1111_2222; cnt_i = 2'b11;
        cycle();
        rst = 1'b1;
        cycle();
        check_val("rst_hold_scr", 256'(scr_o), 256'(0));
        check_val("rst_hold_cnt", 256'(cnt_o), 256'(0));
        rst = 1'b0;

        // Saturation of the narrow counter, then clear against a stall.
        for (int i = 0; i < 5; i++) begin
            stall = 6'b001111;
            randomize_inputs();
            cycle();
        end
        check_val("sat_perf2", 256'(perf_stall2), 256'(3));
        check_val("sat_perf",  256'(perf_stall),  256'(5));
        perf_clr = 1'b1; stall = 6'b011111;
        cycle();
        check_val("clr_perf2", 256'(perf_stall2), 256'(0));
        check_val("clr_perf",  256'(perf_stall),  256'(0));
        perf_clr = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            stall    = 6'($urandom);
            flush    = ($urandom_range(0, 7) == 0);
            perf_clr = ($urandom_range(0, 15) == 0);
            rst      = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
